// File: rtl/vga_sync_receiver.sv
// VGA sync receiver: measures h/v sync timing, locks onto a stable mode
// and recovers pixel coordinates inside the visible window.
//
// Ports:
//   clock        pixel clock, one pixel per cycle
//   rst          synchronous active-high reset
//   h_sync_in    horizontal sync, active low
//   v_sync_in    vertical sync, active low
//   x_pos        pixel column in the visible window, else 0
//   y_pos        line in the visible window, else 0
//   active_zone  locked and inside the visible window
//   locked       receiver is in the LOCKED state
//   frame_start  one-cycle pulse per v_sync falling edge
//   sync_err     one-cycle pulse when lock is lost
//   h_period     last measured line length in clocks
//   v_period     last measured frame length in lines
module vga_sync_receiver #(
   parameter int H_TOTAL     = 1040,
   parameter int V_TOTAL     = 666,
   parameter int H_VISIBLE   = 800,
   parameter int V_VISIBLE   = 600,
   parameter int H_OFFSET    = 184,
   parameter int V_OFFSET    = 29,
   parameter int LOCK_FRAMES = 2
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        h_sync_in,
   input  logic        v_sync_in,
   output logic [10:0] x_pos,
   output logic [10:0] y_pos,
   output logic        active_zone,
   output logic        locked,
   output logic        frame_start,
   output logic        sync_err,
   output logic [10:0] h_period,
   output logic [10:0] v_period
);

   localparam logic [10:0] CNT_MAX = 11'h7FF;
   localparam logic [10:0] H_TOT   = 11'(H_TOTAL);
   localparam logic [10:0] V_TOT   = 11'(V_TOTAL);
   localparam logic [10:0] H_LO    = 11'(H_OFFSET);
   localparam logic [10:0] V_LO    = 11'(V_OFFSET);
   localparam logic [11:0] H_END   = 12'(H_OFFSET + H_VISIBLE);
   localparam logic [11:0] V_END   = 12'(V_OFFSET + V_VISIBLE);
   localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

   state_t      state, state_nxt;
   logic [3:0]  good_cnt, good_cnt_nxt;
   logic        hs_q, hs_p, vs_q, vs_p;
   logic        hs_fall, vs_fall, ph_sat, loss, in_win;
   logic [10:0] h_phase, v_line;

   assign hs_fall = hs_p & ~hs_q;
   assign vs_fall = vs_p & ~vs_q;
   // Saturation only counts when no h_sync edge rescues the line.
   assign ph_sat  = (h_phase == CNT_MAX) & ~hs_fall;
   assign locked  = (state == LOCKED);

   // Sync inputs reset high so that reset never fakes a falling edge.
   always_ff @(posedge clock) begin
      if (rst) begin
         hs_q <= 1'b1;
         hs_p <= 1'b1;
         vs_q <= 1'b1;
         vs_p <= 1'b1;
      end else begin
         hs_q <= h_sync_in;
         hs_p <= hs_q;
         vs_q <= v_sync_in;
         vs_p <= vs_q;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         h_phase  <= '0;
         h_period <= '0;
         v_line   <= '0;
         v_period <= '0;
      end else begin
         if (hs_fall) begin
            h_phase  <= 11'd1;
            h_period <= h_phase;
         end else if (h_phase != CNT_MAX) begin
            h_phase <= h_phase + 11'd1;
         end
         // A coincident h edge already belongs to the new frame.
         if (vs_fall) begin
            v_period <= v_line;
            v_line   <= {10'd0, hs_fall};
         end else if (hs_fall && v_line != CNT_MAX) begin
            v_line <= v_line + 11'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         state    <= SEARCH;
         good_cnt <= '0;
      end else begin
         state    <= state_nxt;
         good_cnt <= good_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      good_cnt_nxt = good_cnt;
      loss         = 1'b0;
      case (state)
         SEARCH: begin
            good_cnt_nxt = '0;
            if (!ph_sat && vs_fall)
               state_nxt = CHECK;
         end
         CHECK: begin
            if (ph_sat) begin
               state_nxt    = SEARCH;
               good_cnt_nxt = '0;
            end else if (vs_fall) begin
               if (h_period == H_TOT && v_line == V_TOT) begin
                  good_cnt_nxt = good_cnt + 4'd1;
                  if (good_cnt + 4'd1 >= LOCK_N)
                     state_nxt = LOCKED;
               end else begin
                  good_cnt_nxt = '0;
               end
            end
         end
         LOCKED: begin
            loss = (hs_fall && h_phase != H_TOT)
                 | (vs_fall && v_line != V_TOT)
                 | ph_sat;
            if (loss) begin
               state_nxt    = SEARCH;
               good_cnt_nxt = '0;
            end
         end
         default: begin
            state_nxt    = SEARCH;
            good_cnt_nxt = '0;
         end
      endcase
   end

   assign in_win = locked
                 && h_phase >= H_LO && {1'b0, h_phase} < H_END
                 && v_line >= V_LO && {1'b0, v_line} < V_END;

   always_ff @(posedge clock) begin
      if (rst) begin
         x_pos       <= '0;
         y_pos       <= '0;
         active_zone <= 1'b0;
         frame_start <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         x_pos       <= in_win ? h_phase - H_LO : '0;
         y_pos       <= in_win ? v_line - V_LO : '0;
         active_zone <= in_win;
         frame_start <= vs_fall;
         sync_err    <= loss;
      end
   end

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver using a reduced video mode, a timestamp
// based reference model and a few literal expectations.
module tb_vga_sync_receiver;

   localparam int HT  = 40;
   localparam int VT  = 20;
   localparam int HV  = 24;
   localparam int VV  = 12;
   localparam int HO  = 10;
   localparam int VO  = 4;
   localparam int LF  = 2;
   localparam int HSW = 5;
   localparam int VSW = 3;

   logic        clock = 1'b0;
   logic        rst = 1'b1;
   logic        h_sync_in = 1'b1;
   logic        v_sync_in = 1'b1;
   logic [10:0] x_pos, y_pos, h_period, v_period;
   logic        active_zone, locked, frame_start, sync_err;

   vga_sync_receiver #(
      .H_TOTAL(HT), .V_TOTAL(VT), .H_VISIBLE(HV), .V_VISIBLE(VV),
      .H_OFFSET(HO), .V_OFFSET(VO), .LOCK_FRAMES(LF)
   ) dut (
      .clock(clock), .rst(rst),
      .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
      .x_pos(x_pos), .y_pos(y_pos), .active_zone(active_zone),
      .locked(locked), .frame_start(frame_start), .sync_err(sync_err),
      .h_period(h_period), .v_period(v_period)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_bad = 0;
   int cyc = -1;

   // Expected outputs per cycle, indexed by cycle number mod 16.
   int e_x[16], e_y[16], e_hp[16], e_vp[16];
   bit e_az[16], e_lk[16], e_fs[16], e_se[16];

   // Reference model: timestamps of the last edges, edge counts, and a
   // streak of good frames (-1 = searching, >= LF = locked).
   int m_last_hf, m_len, m_vcount, m_vper, m_streak;
   bit m_prev_hs, m_prev_vs;

   int az_cnt, fs_cnt, se_cnt, max_x, max_y, first_x, first_y;
   bit seen_first, prev_az;

   task automatic chk(string nm, int act, int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         if (n_bad <= 30)
            $display("FAIL %s cyc=%0d got=%0d want=%0d", nm, cyc, act, exp);
      end
   endtask

   function automatic int sat11(int v);
      return (v > 2047) ? 2047 : v;
   endfunction

   task automatic zero_at(int c, bit xyz_only);
      int k;
      k = c & 15;
      e_x[k] = 0; e_y[k] = 0; e_az[k] = 0;
      if (!xyz_only) begin
         e_lk[k] = 0; e_hp[k] = 0; e_vp[k] = 0; e_fs[k] = 0; e_se[k] = 0;
      end
   endtask

   // Inputs driven for cycle n are seen as edges during n+1, update the
   // counters for n+2 and reach the coordinate outputs in n+3.
   task automatic model_step(int n, bit hs, bit vs, bit r);
      bit hf, vf, sat, loss, lk;
      int hp, vl, hp2, vl2, k2, k3;
      bit az;
      if (r) begin
         m_last_hf = n; m_len = 0; m_vcount = 0; m_vper = 0;
         m_streak = -1; m_prev_hs = 1; m_prev_vs = 1;
         zero_at(n + 1, 0);
         zero_at(n + 2, 0);
         zero_at(n + 3, 1);
         return;
      end
      hf = m_prev_hs && !hs;
      vf = m_prev_vs && !vs;
      hp = sat11(n - m_last_hf);
      vl = sat11(m_vcount);
      sat = (hp == 2047) && !hf;
      loss = 0;
      if (m_streak >= LF) begin
         loss = (hf && hp != HT) || (vf && vl != VT) || sat;
         if (loss) m_streak = -1;
      end else if (sat) begin
         m_streak = -1;
      end else if (vf) begin
         if (m_streak < 0) m_streak = 0;
         else if (m_len == HT && vl == VT) m_streak++;
         else m_streak = 0;
      end
      if (hf) begin
         m_len = hp;
         m_last_hf = n;
      end
      if (vf) begin
         m_vper = vl;
         m_vcount = hf ? 1 : 0;
      end else if (hf) begin
         m_vcount++;
      end
      m_prev_hs = hs;
      m_prev_vs = vs;
      lk = (m_streak >= LF);
      k2 = (n + 2) & 15;
      e_lk[k2] = lk; e_hp[k2] = m_len; e_vp[k2] = m_vper;
      e_fs[k2] = vf; e_se[k2] = loss;
      hp2 = sat11(n + 1 - m_last_hf);
      vl2 = sat11(m_vcount);
      az = lk && hp2 >= HO && hp2 < HO + HV && vl2 >= VO && vl2 < VO + VV;
      k3 = (n + 3) & 15;
      e_az[k3] = az;
      e_x[k3] = az ? hp2 - HO : 0;
      e_y[k3] = az ? vl2 - VO : 0;
   endtask

   always @(negedge clock) begin : cmp
      int k;
      if (cyc >= 3) begin
         k = cyc & 15;
         chk("x_pos", int'(x_pos), e_x[k]);
         chk("y_pos", int'(y_pos), e_y[k]);
         chk("active_zone", int'(active_zone), int'(e_az[k]));
         chk("locked", int'(locked), int'(e_lk[k]));
         chk("frame_start", int'(frame_start), int'(e_fs[k]));
         chk("sync_err", int'(sync_err), int'(e_se[k]));
         chk("h_period", int'(h_period), e_hp[k]);
         chk("v_period", int'(v_period), e_vp[k]);
         if (active_zone) begin
            az_cnt++;
            if (int'(x_pos) > max_x) max_x = int'(x_pos);
            if (int'(y_pos) > max_y) max_y = int'(y_pos);
            if (!prev_az && !seen_first) begin
               first_x = int'(x_pos);
               first_y = int'(y_pos);
               seen_first = 1;
            end
         end
         if (frame_start) fs_cnt++;
         if (sync_err) se_cnt++;
         prev_az = active_zone;
      end
   end

   task automatic clear_obs();
      az_cnt = 0; fs_cnt = 0; se_cnt = 0;
      max_x = -1; max_y = -1; first_x = -1; first_y = -1;
      seen_first = 0;
   endtask

   task automatic drive(bit r, bit hs, bit vs);
      @(posedge clock);
      #1;
      cyc = cyc + 1;
      rst = r;
      h_sync_in = hs;
      v_sync_in = vs;
      model_step(cyc, hs, vs, r);
   endtask

   // One frame; line sl is one clock short, rl gets a reset at column 20.
   task automatic frame(int nl, int sl, int rl);
      bit pend;
      int len;
      pend = 0;
      for (int l = 0; l < nl; l++) begin
         len = (l == sl) ? HT - 1 : HT;
         for (int i = 0; i < len; i++) begin
            if (l == rl && i == 20) clear_obs();
            drive(l == rl && i == 20, i >= HSW, l >= VSW);
            if (pend) begin
               pend = 0;
               chk("rst_x", int'(x_pos), 0);
               chk("rst_y", int'(y_pos), 0);
               chk("rst_az", int'(active_zone), 0);
               chk("rst_locked", int'(locked), 0);
               chk("rst_se", int'(sync_err), 0);
               chk("rst_hp", int'(h_period), 0);
               chk("rst_vp", int'(v_period), 0);
            end
            if (l == rl && i == 20) pend = 1;
         end
      end
   endtask

   initial begin
      clear_obs();
      prev_az = 0;
      repeat (3) drive(1, 1, 1);
      drive(0, 1, 1);
      chk("init_x", int'(x_pos), 0);
      chk("init_y", int'(y_pos), 0);
      chk("init_az", int'(active_zone), 0);
      chk("init_locked", int'(locked), 0);
      chk("init_fs", int'(frame_start), 0);
      chk("init_se", int'(sync_err), 0);
      chk("init_hp", int'(h_period), 0);
      chk("init_vp", int'(v_period), 0);

      frame(VT, -1, -1);
      frame(VT, -1, -1);
      chk("prelock", int'(locked), 0);
      frame(VT, -1, -1);
      chk("lock3", int'(locked), 1);
      chk("lock_hp", int'(h_period), HT);
      chk("lock_vp", int'(v_period), VT);

      clear_obs();
      frame(VT, -1, -1);
      chk("act_cnt", az_cnt, 288);
      chk("max_x", max_x, 23);
      chk("max_y", max_y, 11);
      chk("first_x", first_x, 0);
      chk("first_y", first_y, 0);
      chk("fs_once", fs_cnt, 1);
      chk("no_err", se_cnt, 0);

      clear_obs();
      frame(VT, 6, -1);
      chk("short_err", se_cnt, 1);
      chk("short_unlock", int'(locked), 0);
      frame(VT, -1, -1);
      frame(VT, -1, -1);
      chk("relock_early", int'(locked), 0);
      frame(VT, -1, -1);
      chk("relock", int'(locked), 1);

      clear_obs();
      repeat (2100) drive(0, 1, 1);
      chk("sat_err", se_cnt, 1);
      chk("sat_unlock", int'(locked), 0);
      chk("sat_x", int'(x_pos), 0);
      chk("sat_y", int'(y_pos), 0);
      repeat (3) frame(VT, -1, -1);
      chk("sat_relock", int'(locked), 1);

      frame(VT, -1, 8);
      chk("rst_no_fs", fs_cnt, 0);
      chk("rst_no_se", se_cnt, 0);
      repeat (3) frame(VT, -1, -1);
      chk("rst_relock", int'(locked), 1);

      clear_obs();
      frame(18, -1, -1);
      frame(1, -1, -1);
      chk("vshort_vp", int'(v_period), 18);
      chk("vshort_err", se_cnt, 1);
      chk("vshort_unlock", int'(locked), 0);
      repeat (4) drive(0, 1, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
